// File: rtl/bec_pkg.sv
// Shared constants, FSM encoding and the GF(2^163) squarer for the projective-to-affine stage.
package bec_pkg;

  localparam int unsigned M            = 163;
  localparam logic [M-1:0] POLY        = 163'hC9;
  localparam int unsigned BEC_AFF_LAT  = 26569;
  localparam int unsigned LADDER_ITERS = 161;

  typedef enum logic [2:0] {
    StIdle,
    StSqr,
    StMul,
    StFsqr,
    StFmul,
    StDone
  } bec_state_e;

  // Squaring in characteristic 2 only spreads the bits; the rest is folding x^163 back down.
  function automatic logic [M-1:0] gf163_sqr(input logic [M-1:0] a);
    logic [2*M-2:0] s;
    s = '0;
    for (int i = 0; i < int'(M); i++) begin
      s[2*i] = a[i];
    end
    for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
      if (s[i]) begin
        s[i-int'(M) +: 8] = s[i-int'(M) +: 8] ^ POLY[7:0];
      end
    end
    return s[M-1:0];
  endfunction

endpackage

// File: rtl/bec_proj2aff_if.sv
// Handshake between the ladder/host side (master) and the affine-conversion stage (slave).
interface bec_proj2aff_if;
  import bec_pkg::*;

  logic         start;
  logic [M-1:0] w_in;
  logic [M-1:0] z_in;
  logic         busy;
  logic         valid;
  logic [M-1:0] w_aff;
  logic         err;

  modport master (
    output start, w_in, z_in,
    input  busy, valid, w_aff, err
  );

  modport slave (
    input  start, w_in, z_in,
    output busy, valid, w_aff, err
  );

endinterface

// File: rtl/gf163_mul_serial.sv
// Bit-serial MSB-first GF(2^163) multiplier; p is the finished product while rdy is high.
module gf163_mul_serial
  import bec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p,
  output logic         rdy
);

  logic         run_q;
  logic [7:0]   cnt_q;
  logic [M-1:0] acc_q;
  logic [M-1:0] acc_d;
  logic [M-1:0] a_q;
  logic [M-1:0] b_q;

  always_comb begin
    acc_d = {acc_q[M-2:0], 1'b0} ^ (acc_q[M-1] ? POLY : '0) ^ (b_q[M-1] ? a_q : '0);
  end

  // The last step's result is exposed combinationally so the caller sees it on the 163rd cycle.
  assign p   = acc_d;
  assign rdy = run_q && (cnt_q == 8'(M - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (go) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      acc_q <= '0;
      a_q   <= a;
      b_q   <= b;
    end else if (run_q) begin
      acc_q <= acc_d;
      b_q   <= {b_q[M-2:0], 1'b0};
      cnt_q <= cnt_q + 8'd1;
      if (rdy) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bec_proj2aff.sv
// Projective (W, Z) to affine W/Z over GF(2^163) via Fermat inversion Z^(2^163-2).
// Optional macro BEC_AFF_ZERO_CHECK_EN: short-circuits Z==0 to a one-cycle err result.
module bec_proj2aff
  import bec_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  bec_proj2aff_if.slave  bus
);

  bec_state_e   state_q, state_d;
  logic [M-1:0] reg_w_q, reg_w_d;
  logic [M-1:0] reg_z_q, reg_z_d;
  logic [M-1:0] r_q, r_d;
  logic [7:0]   iter_q, iter_d;
  logic [M-1:0] w_aff_q, w_aff_d;

  logic         mul_go;
  logic [M-1:0] mul_a;
  logic [M-1:0] mul_b;
  logic [M-1:0] mul_p;
  logic         mul_rdy;

`ifdef BEC_AFF_ZERO_CHECK_EN
  logic err_q, err_d;
`endif

  // The squarer output goes straight into the multiplier's latched b operand, so SQR/FSQR
  // need no separate t register.
  gf163_mul_serial u_mul (
    .clk (clk),
    .rst (rst),
    .go  (mul_go),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .rdy (mul_rdy)
  );

  always_comb begin
    state_d = state_q;
    reg_w_d = reg_w_q;
    reg_z_d = reg_z_q;
    r_d     = r_q;
    iter_d  = iter_q;
    w_aff_d = w_aff_q;
`ifdef BEC_AFF_ZERO_CHECK_EN
    err_d   = err_q;
`endif
    mul_go  = 1'b0;
    mul_a   = reg_z_q;
    mul_b   = gf163_sqr(r_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          reg_w_d = bus.w_in;
          reg_z_d = bus.z_in;
          r_d     = bus.z_in;
          iter_d  = 8'd1;
          state_d = StSqr;
`ifdef BEC_AFF_ZERO_CHECK_EN
          if (bus.z_in == '0) begin
            w_aff_d = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StSqr: begin
        mul_go  = 1'b1;
        state_d = StMul;
      end
      StMul: begin
        if (mul_rdy) begin
          r_d = mul_p;
          if (iter_q == 8'(LADDER_ITERS)) begin
            state_d = StFsqr;
          end else begin
            iter_d  = iter_q + 8'd1;
            state_d = StSqr;
          end
        end
      end
      StFsqr: begin
        // r = Z^(2^162-1) here, so its square is Z^-1.
        mul_go  = 1'b1;
        mul_a   = reg_w_q;
        state_d = StFmul;
      end
      StFmul: begin
        if (mul_rdy) begin
          r_d     = mul_p;
          w_aff_d = mul_p;
`ifdef BEC_AFF_ZERO_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      reg_w_q <= '0;
      reg_z_q <= '0;
      r_q     <= '0;
      iter_q  <= '0;
      w_aff_q <= '0;
`ifdef BEC_AFF_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      reg_w_q <= reg_w_d;
      reg_z_q <= reg_z_d;
      r_q     <= r_d;
      iter_q  <= iter_d;
      w_aff_q <= w_aff_d;
`ifdef BEC_AFF_ZERO_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy  = (state_q != StIdle) && (state_q != StDone);
  assign bus.valid = (state_q == StDone);
  assign bus.w_aff = w_aff_q;
`ifdef BEC_AFF_ZERO_CHECK_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_bec_proj2aff.sv
// Randomized self-checking bench for bec_proj2aff against a schoolbook GF(2^163) model.
module tb_bec_proj2aff;
  import bec_pkg::*;

`ifdef BEC_AFF_ZERO_CHECK_EN
  localparam int   ZLAT = 1;
  localparam logic ZERR = 1'b1;
`else
  localparam int   ZLAT = BEC_AFF_LAT;
  localparam logic ZERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bec_proj2aff_if bus ();

  bec_proj2aff dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Full carry-less product, then polynomial long division by f(x).
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] prod;
    logic [2*M-1:0] f;
    prod = '0;
    f    = '0;
    f[M] = 1'b1;
    f[M-1:0] = POLY;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) prod = prod ^ ({{M{1'b0}}, a} << i);
    end
    for (int i = 2 * int'(M) - 1; i >= int'(M); i--) begin
      if (prod[i]) prod = prod ^ (f << (i - int'(M)));
    end
    return prod[M-1:0];
  endfunction

  // Z^(2^163-2) as the product of Z^(2^i) for i = 1..162.
  function automatic logic [M-1:0] ref_inv(input logic [M-1:0] z);
    logic [M-1:0] acc;
    logic [M-1:0] sq;
    acc = '0;
    acc[0] = 1'b1;
    sq = z;
    for (int i = 1; i < int'(M); i++) begin
      sq  = ref_mul(sq, sq);
      acc = ref_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] rnd_elem();
    logic [191:0] x;
    x = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return x[M-1:0];
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the sampling edge.
  task automatic start_op(input logic [M-1:0] w, input logic [M-1:0] z);
    bus.start = 1'b1;
    bus.w_in  = w;
    bus.z_in  = z;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles until valid; optionally pokes a stray start at cycle poke_at.
  task automatic wait_valid(input int poke_at, output int lat, output logic busy_ok);
    int c;
    lat     = 0;
    busy_ok = 1'b1;
    for (c = 1; c <= BEC_AFF_LAT + 10; c++) begin
      if (c == poke_at) begin
        bus.start = 1'b1;
        bus.w_in  = rnd_elem();
        bus.z_in  = rnd_elem() | 163'h1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.valid) begin
        lat = c;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  logic [M-1:0] w1, z1, exp1, w3;
  logic [M-1:0] x_inv;
  int           lat;
  logic         busy_ok;

  initial begin
    bus.start = 1'b0;
    bus.w_in  = '0;
    bus.z_in  = '0;
    x_inv = '0;
    x_inv[M-1] = 1'b1;
    x_inv[6:0] = 7'b1100100;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", M'(bus.busy), '0);
    check_eq("rst_valid", M'(bus.valid), '0);
    check_eq("rst_w_aff", bus.w_aff, '0);
    check_eq("rst_err", M'(bus.err), '0);

    // Random operands with a stray start at cycle 100.
    w1   = rnd_elem();
    z1   = rnd_elem() | 163'h1;
    exp1 = ref_mul(w1, ref_inv(z1));
    start_op(w1, z1);
    wait_valid(100, lat, busy_ok);
    check_eq("op1_latency", M'(lat), M'(BEC_AFF_LAT));
    check_eq("op1_busy_held", M'(busy_ok), M'(1));
    check_eq("op1_busy_at_valid", M'(bus.busy), '0);
    check_eq("op1_w_aff", bus.w_aff, exp1);
    check_eq("op1_err", M'(bus.err), '0);
    @(negedge clk);
    check_eq("op1_valid_pulse", M'(bus.valid), '0);
    check_eq("op1_w_aff_held", bus.w_aff, exp1);

    // Abort with rst at cycle 5000.
    start_op(rnd_elem(), rnd_elem() | 163'h1);
    repeat (4999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", M'(bus.busy), '0);
    check_eq("abort_valid", M'(bus.valid), '0);
    check_eq("abort_w_aff", bus.w_aff, '0);

    // Fresh start after abort: W=1, Z=x.
    start_op(163'h1, 163'h2);
    wait_valid(0, lat, busy_ok);
    check_eq("op2_latency", M'(lat), M'(BEC_AFF_LAT));
    check_eq("op2_busy_held", M'(busy_ok), M'(1));
    check_eq("op2_w_aff_const", bus.w_aff, x_inv);
    check_eq("op2_w_aff_model", bus.w_aff, ref_mul(163'h1, ref_inv(163'h2)));
    check_eq("op2_err", M'(bus.err), '0);

    // start held over the DONE cycle (ignored) and the following IDLE cycle (accepted).
    w3 = rnd_elem();
    bus.start = 1'b1;
    bus.w_in  = w3;
    bus.z_in  = '0;
    @(negedge clk);
    check_eq("done_start_ignored", M'(bus.busy), '0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(0, lat, busy_ok);
    check_eq("zero_latency", M'(lat), M'(ZLAT));
    check_eq("zero_busy_held", M'(busy_ok), M'(1));
    check_eq("zero_w_aff", bus.w_aff, ref_mul(w3, ref_inv('0)));
    check_eq("zero_err", M'(bus.err), M'(ZERR));
    @(negedge clk);
    check_eq("zero_valid_pulse", M'(bus.valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bec_proj2aff.md
Name: bec_proj2aff

Overview:
- Downstream stage of the GF(2^163) binary-Edwards Montgomery-ladder scalar multiplier.
- Captures the projective result (W, Z) when the ladder pulses done, then computes the affine coordinate w_aff = W · Z^-1 mod f(x), where f(x) = x^163 + x^7 + x^6 + x^3 + 1.
- Inversion uses Fermat: Z^(2^163−2), built from a one-cycle combinational squarer and a bit-serial multiplier.
- Result is held for the host/wishbone side.

Parameters:
- M, 163, field degree / operand width
- POLY, 163'hC9, reduction polynomial low terms (bits 7, 6, 3, 0; x^163 implicit)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse, wired to ladder done
- w_in  input  163  projective W, wired to ladder wout
- z_in  input  163  projective Z, wired to ladder zout
- busy  output  1  high from the cycle after start is accepted until valid
- valid  output  1  one-cycle pulse: w_aff is updated
- w_aff  output  163  affine result, held until the next valid
- err  output  1  Z==0 flag, held with w_aff (macro-dependent)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, valid=0, w_aff=0, err=0, state=IDLE, all internal registers 0.
- States: IDLE, SQR, MUL, FSQR, FMUL, DONE.
- IDLE:
  - start=1 → capture regW<=w_in, regZ<=z_in, r<=z_in, iter<=1; go to SQR.
  - start=0 → stay in IDLE.
- SQR (1 cycle): t <= r^2 mod f; go to MUL.
- MUL (exactly 163 cycles): serial multiply r <= t·regZ, MSB-first, one multiplier bit per cycle.
  - On the last cycle: iter==161 → FSQR; otherwise iter++ and → SQR.
- FSQR (1 cycle): t <= r^2. At this point r = Z^(2^162−1), so t = Z^-1. Go to FMUL.
- FMUL (163 cycles): r <= t·regW; then → DONE.
- DONE (1 cycle): w_aff<=r, valid=1, busy=0; → IDLE.
- Latency: valid is high exactly 26569 rising edges after the edge that sampled start.
  - Accounting: 161×164 + 1 + 163, with the DONE cycle being the 26569th.
- start while busy: ignored. No queueing and no error; the captured operands are not disturbed.
- start in the DONE cycle: ignored. A start pulse in IDLE the following cycle is accepted.
- rst mid-operation: abort on that edge and return to reset values. The previous w_aff is cleared to 0.
- w_aff and err change only in DONE (or on rst).
- Arithmetic:
  - Addition is XOR.
  - The squarer is purely combinational: bit spread, then reduction by POLY.
  - The multiplier reduces each step: acc = (acc<<1) ^ (acc[162] ? POLY : 0) ^ (b_i ? a : 0).
  - All values stay 163 bits; no carries.

Optional Feature:
- Macro BEC_AFF_ZERO_CHECK_EN.
- Defined: if z_in==0 at capture, IDLE goes straight to DONE on the next cycle (latency 1), with w_aff=0 and err=1. Otherwise err=0.
- Undefined: err is tied 0. Z=0 runs the full sequence (latency 26569) and naturally yields w_aff=0.

Decomposition:
- Shared package bec_pkg:
  - constants M=163 and POLY
  - BEC_AFF_LAT=26569
  - state enum encoding (3-bit)
  - the squaring function gf163_sqr
- One sub-module, gf163_mul_serial, with ports:
  - clk, rst, go, a[162:0], b[162:0] → p[162:0], rdy
  - behaviour: rdy pulses 163 cycles after go
- The FSM instantiates a single multiplier instance, shared between the MUL and FMUL phases.

Test Plan:
- z_in=1, w_in=163'h5, start pulse → after 26569 edges, valid=1 for one cycle, w_aff=163'h5, err=0.
- w_in=z_in=163'h3_0000_0000_1234_ABCD → w_aff=1.
- z_in=163'h2 (x), w_in=1 → w_aff = x^162 + x^6 + x^5 + x^2 = {1'b1, 155'b0, 7'b1100100}.
- Second start pulse 100 cycles after the first, with different operands → ignored; result matches the first operands and busy stays high throughout.
- rst asserted at cycle 5000 of an operation → next cycle busy=0, w_aff=0. A fresh start then completes with the correct result at full latency.
- z_in=0, w_in=7:
  - with BEC_AFF_ZERO_CHECK_EN: valid 1 cycle after start, err=1, w_aff=0.
  - without the macro: valid after 26569 edges, err=0, w_aff=0.
